// File: rtl/mem_uncache_wbuf.sv
// Posted uncached write buffer and SRAM-like bus bridge: stores retire at once unless full; loads stall,
// drain older stores in order, then take at least two bus cycles. Backpressure comes only from addr_ok/data_ok.
module mem_uncache_wbuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [3:0]               calWE,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        Memdata,
    output logic                     stall,
    output logic                     wbuf_empty,
    output logic [$clog2(DEPTH):0]   wbuf_count,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, WREQ, WDATA, RREQ, RDATA} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;

    logic [ADDR_W-1:0]  addr_mem [DEPTH];
    logic [1:0]         size_mem [DEPTH];
    logic [DATA_W-1:0]  data_mem [DEPTH];

    logic               we_ok;
    logic [1:0]         we_size;
    logic               push, pop, rd_done;

    // Only naturally shaped lane masks become bus transfers; anything else is silently dropped.
    always_comb begin
        we_ok   = 1'b1;
        we_size = 2'd0;
        case (calWE)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: we_size = 2'd0;
            4'b0011, 4'b1100:                   we_size = 2'd1;
            4'b1111:                            we_size = 2'd2;
            default:                            we_ok   = 1'b0;
        endcase
    end

    assign push    = MemWrite & ~MemRead & we_ok & (count_q != FULL);
    assign pop     = (state_q == WDATA) & mem_data_ok;
    assign rd_done = (state_q == RDATA) & mem_data_ok;

    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign rdata_d  = rd_done ? mem_rdata : rdata_q;
    assign done_d   = rd_done;

    assign stall      = (MemRead & ~rd_done) | (MemWrite & ~MemRead & we_ok & (count_q == FULL));
    assign Memdata    = rd_done ? mem_rdata : rdata_q;
    assign wbuf_empty = (count_q == '0);
    assign wbuf_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= addr;
            size_mem[wr_ptr_q] <= we_size;
            data_mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
        end
    end

    // done_q blocks a second read while the pipeline is still presenting the completed load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0)
                    state_d = WREQ;
                else if (MemRead && !done_q)
                    state_d = RREQ;
            end
            WREQ:    if (mem_addr_ok) state_d = WDATA;
            WDATA:   if (mem_data_ok) state_d = IDLE;
            RREQ:    if (mem_addr_ok) state_d = RDATA;
            RDATA:   if (mem_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WREQ: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_size  = size_mem[rd_ptr_q];
                mem_addr  = addr_mem[rd_ptr_q];
                mem_wdata = data_mem[rd_ptr_q];
            end
            RREQ: begin
                mem_req  = 1'b1;
                mem_size = 2'd2;
                mem_addr = {addr[ADDR_W-1:2], 2'b00};
            end
            default: ;
        endcase
    end

    a_no_rw_both: assert property (@(posedge clk) disable iff (!resetn) !(MemRead && MemWrite));

endmodule

// File: tb/tb_mem_uncache_wbuf.sv
// Bench for mem_uncache_wbuf: a bus-slave model checks every accepted transaction against an expected queue,
// and a cycle monitor checks occupancy, stall and load data against a small behavioural model.
`timescale 1ns/1ps
module tb_mem_uncache_wbuf;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [3:0]  calWE = 4'd0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] Memdata;
    logic        stall, wbuf_empty;
    logic [2:0]  wbuf_count;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;

    always #5 clk = ~clk;

    mem_uncache_wbuf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .MemRead(MemRead), .MemWrite(MemWrite), .calWE(calWE),
        .addr(addr), .wdata(wdata), .Memdata(Memdata), .stall(stall), .wbuf_empty(wbuf_empty),
        .wbuf_count(wbuf_count), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] exp_rd[$];

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit we_valid(input logic [3:0] w);
        return w inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Bus slave: drives handshakes on the falling edge, checks each accepted request.
    int          addr_delay = 0, data_delay = 0;
    bit          addr_block = 0;
    logic [31:0] rd_val = '0;
    bit          pend = 0, pend_wr = 0, dok_wr = 0, dok_rd = 0;
    int          acnt = 0, dcnt = 0, n_wr = 0, n_rd = 0;

    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            dok_wr = 0;
            dok_rd = 0;
            if (!resetn) begin
                pend = 0;
                acnt = addr_delay;
            end else if (pend) begin
                if (dcnt == 0) begin
                    mem_data_ok = 1'b1;
                    pend = 0;
                    if (pend_wr) dok_wr = 1;
                    else begin
                        dok_rd = 1;
                        mem_rdata = rd_val;
                    end
                end else dcnt--;
            end else if (mem_req && !addr_block) begin
                if (acnt == 0) begin
                    mem_addr_ok = 1'b1;
                    pend = 1;
                    pend_wr = mem_wr;
                    dcnt = data_delay;
                    acnt = addr_delay;
                    if (mem_wr) n_wr++; else n_rd++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL bus_unexpected: got wr=%0b addr=%0h, no request expected", mem_wr, mem_addr);
                    end else begin
                        t = exp_q.pop_front();
                        chk("bus_wr", mem_wr, t.wr);
                        chk("bus_size", mem_size, t.sz);
                        chk("bus_addr", mem_addr, t.a);
                        if (t.wr) chk("bus_wdata", mem_wdata, t.d);
                    end
                end else acnt--;
            end
        end
    end

    // Cycle monitor with occupancy/stall model.
    int mcount = 0, maxcnt = 0, req_hi = 0;
    bit saw_pp2 = 0;

    initial begin
        bit ok, push, pop, es;
        forever begin
            @(negedge clk); #1;
            if (!resetn) mcount = 0;
            else begin
                ok = we_valid(calWE);
                chk("count", wbuf_count, mcount);
                chk("empty", wbuf_empty, mcount == 0);
                push = MemWrite && !MemRead && ok && (mcount < DEPTH);
                pop  = dok_wr;
                es   = MemRead ? !dok_rd : (MemWrite && ok && mcount == DEPTH);
                chk("stall", stall, es);
                if (MemRead && dok_rd) begin
                    if (exp_rd.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL load_unexpected: got %0h, no load expected", Memdata);
                    end else chk("Memdata", Memdata, exp_rd.pop_front());
                end
                if (push && pop && mcount == 2) saw_pp2 = 1;
                mcount = mcount + int'(push) - int'(pop);
                if (mcount > maxcnt) maxcnt = mcount;
                if (mem_req) req_hi++;
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                            input logic [1:0] sz, output int sc);
        int t = 0;
        txn_t x;
        sc = 0;
        x.wr = 1'b1; x.sz = sz; x.a = a; x.d = d;
        exp_q.push_back(x);
        MemWrite = 1'b1; calWE = we; addr = a; wdata = d;
        @(negedge clk); #1;
        while (stall && t < 300) begin
            sc++; t++;
            @(negedge clk); #1;
        end
        if (t >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL store_timeout: stall still %0b, required 0", stall);
        end
        @(posedge clk); #2;
        MemWrite = 1'b0; calWE = 4'd0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] v, input bit extra, output int sc);
        int t = 0;
        txn_t x;
        sc = 0;
        x.wr = 1'b0; x.sz = 2'd2; x.a = {a[31:2], 2'b00}; x.d = '0;
        exp_q.push_back(x);
        exp_rd.push_back(v);
        rd_val = v; addr = a; MemRead = 1'b1;
        @(negedge clk); #1;
        while (stall && t < 300) begin
            sc++; t++;
            @(negedge clk); #1;
        end
        if (t >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: stall still %0b, required 0", stall);
        end
        @(posedge clk); #2;
        if (extra) begin
            @(posedge clk); #2;
        end
        MemRead = 1'b0;
    endtask

    task automatic wait_empty();
        int t = 0;
        @(negedge clk); #1;
        while (!(wbuf_empty && !pend && !mem_req) && t < 300) begin
            t++;
            @(negedge clk); #1;
        end
        if (t >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: count %0d, required 0", wbuf_count);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        int sc, tot, bw, br;
        logic [7:0] b;

        #1;
        chk("rst_outs_a", {Memdata, stall, wbuf_count, mem_req, mem_wr, mem_size}, '0);
        chk("rst_outs_b", {mem_addr, mem_wdata}, '0);
        chk("rst_empty", wbuf_empty, 1'b1);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk); #2;

        // 1) four word stores, fast bus
        bw = n_wr; tot = 0;
        for (int i = 0; i < 4; i++) begin
            b = 8'((i + 1) * 17);
            do_store(32'hBFAF_F000 + 32'(4 * i), 4'hF, {4{b}}, 2'd2, sc);
            tot += sc;
        end
        wait_empty();
        chk("t1_no_stall", tot, 0);
        chk("t1_writes", n_wr - bw, 4);
        chk("t1_empty", wbuf_empty, 1'b1);

        // 2) addr_ok withheld: fifth store stalls until the first write completes
        bw = n_wr; maxcnt = 0; addr_block = 1;
        for (int i = 0; i < 4; i++)
            do_store(32'hA000_0100 + 32'(4 * i), 4'b0011, 32'h0000_1000 + 32'(i), 2'd1, sc);
        fork
            begin
                do_store(32'hA000_0200, 4'b1100, 32'h5555_0000, 2'd1, sc);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("t2_full", wbuf_count, 3'd4);
                addr_block = 0;
            end
        join
        chk("t2_fifth_stalled", sc >= 6, 1'b1);
        wait_empty();
        chk("t2_maxcnt", maxcnt, 4);
        chk("t2_writes", n_wr - bw, 5);

        // 3) byte store then word load: write goes first, load waits for the drain
        bw = n_wr; br = n_rd;
        do_store(32'hBFD0_0003, 4'b1000, 32'hAB00_0000, 2'd0, sc);
        do_load(32'hBFD0_0000, 32'hCAFE_F00D, 1'b0, sc);
        chk("t3_load_latency", sc, 5);
        wait_empty();
        chk("t3_write_then_read", {n_wr - bw, n_rd - br}, {32'd1, 32'd1});

        // 4) slow data_ok, MemRead held one extra cycle
        br = n_rd; data_delay = 2;
        do_load(32'hBFD0_0012, 32'h1234_5678, 1'b1, sc);
        repeat (4) @(posedge clk);
        #2;
        chk("t4_one_read", n_rd - br, 1);
        chk("t4_Memdata_hold", Memdata, 32'h1234_5678);
        data_delay = 0;

        // 5) push and pop coincide at count 2, then keep storing through pointer wrap
        bw = n_wr; saw_pp2 = 0; addr_block = 1;
        do_store(32'hB000_0000, 4'hF, 32'hD000_0000, 2'd2, sc);
        do_store(32'hB000_0004, 4'hF, 32'hD000_0001, 2'd2, sc);
        addr_block = 0;
        @(posedge clk); #2;
        for (int i = 2; i < 9; i++)
            do_store(32'hB000_0000 + 32'(4 * i), 4'hF, 32'hD000_0000 + 32'(i), 2'd2, sc);
        wait_empty();
        chk("t5_push_pop_at_2", saw_pp2, 1'b1);
        chk("t5_writes", n_wr - bw, 9);

        // illegal lane mask: dropped, no stall, no bus write
        bw = n_wr;
        MemWrite = 1'b1; calWE = 4'b0101; addr = 32'hB100_0000; wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #2 MemWrite = 1'b0; calWE = 4'd0;
        repeat (4) @(posedge clk);
        #2;
        chk("drop_no_write", n_wr - bw, 0);

        // 6) reset while a write waits for data_ok with three entries held
        addr_block = 1;
        for (int i = 0; i < 3; i++)
            do_store(32'hC000_0000 + 32'(4 * i), 4'hF, 32'hE000_0000 + 32'(i), 2'd2, sc);
        data_delay = 20; addr_block = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_count_before", wbuf_count, 3'd3);
        resetn = 1'b0;
        #1;
        chk("t6_rst_outs_a", {Memdata, stall, wbuf_count, mem_req, mem_wr, mem_size}, '0);
        chk("t6_rst_outs_b", {mem_addr, mem_wdata}, '0);
        chk("t6_rst_empty", wbuf_empty, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        data_delay = 0; req_hi = 0;
        repeat (10) @(posedge clk);
        #2;
        chk("t6_no_req_after", req_hi, 0);
        chk("t6_empty_after", wbuf_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
